taitosj_hs_bridge: RTL and testbench
====================================

TAITOSJ_HS_BRIDGE -- requirements
Module: taitosj_hs_bridge

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- BASE_ADDR, 16'h8000, CPU address of the first byte of the work-RAM window.
- ADDR_BITS, 11, work-RAM address width (2 KB).
- SETTLE, 2, idle cycles between ownership change and first hiscore access (1..15).

REQ-002 Ports, one per line: name, direction, width, meaning.
- clkm_32MHZ, in, 1, sole clock.
- RESET_n, in, 1, asynchronous active-low reset.
- pause_cpu, in, 1, CPU halted; high = bus free for hiscore.
- hs_access_read, in, 1, hiscore read intent.
- hs_access_write, in, 1, hiscore write intent.
- hs_address, in, 16, absolute CPU address from hiscore.
- hs_data_in, in, 8, write data from hiscore.
- hs_write, in, 1, write strobe from hiscore (level).
- hs_data_out, out, 8, read data to hiscore.
- hs_granted, out, 1, bridge owns RAM for hiscore.
- cpu_addr, in, ADDR_BITS, CPU RAM address.
- cpu_wdata, in, 8, CPU write data.
- cpu_we, in, 1, CPU write enable.
- ram_addr, out, ADDR_BITS, muxed RAM address.
- ram_wdata, out, 8, muxed RAM write data.
- ram_we, out, 1, muxed RAM write enable.
- ram_q, in, 8, RAM read data, one cycle after ram_addr.

Function
REQ-003 The FSM SHALL have states CPU_OWN, SETTLE_IN, HS_OWN.
REQ-004 CPU_OWN -> SETTLE_IN SHALL occur when pause_cpu=1 and (hs_access_read|hs_access_write)=1.
REQ-005 SETTLE_IN SHALL load a counter with SETTLE, decrement each cycle, and enter HS_OWN on the cycle after it reaches 0; hs_granted=0 throughout.
REQ-006 HS_OWN -> CPU_OWN SHALL occur when both intents are low, or immediately when pause_cpu=0 (abort).
REQ-007 SETTLE_IN -> CPU_OWN SHALL occur when pause_cpu=0 or both intents drop; the counter is discarded.
REQ-008 hs_granted SHALL be registered high only in HS_OWN.
REQ-009 In CPU_OWN and SETTLE_IN, ram_addr/ram_wdata/ram_we SHALL pass cpu_addr/cpu_wdata/cpu_we combinationally.
REQ-010 In HS_OWN, ram_addr SHALL be hs_address[ADDR_BITS-1:0] minus BASE_ADDR[ADDR_BITS-1:0] (wraps modulo 2^ADDR_BITS), and cpu_we SHALL be ignored.
REQ-011 In HS_OWN, ram_we SHALL be high on every cycle with hs_write=1 and the address in the window; one byte is written per asserted cycle.
REQ-012 hs_data_out SHALL be a register loaded from ram_q each cycle in HS_OWN; total read latency from hs_address change is 2 cycles.
REQ-013 hs_data_out SHALL hold its last value outside HS_OWN.
REQ-014 A write in the same cycle as an abort (pause_cpu falls) SHALL NOT reach RAM.
REQ-015 hs_write in CPU_OWN or SETTLE_IN SHALL be dropped silently, with no queueing.

Reset
REQ-016 RESET_n low SHALL asynchronously force CPU_OWN, settle counter 0, hs_granted 0, hs_data_out 8'h00.
REQ-017 Reset asserted mid-HS_OWN SHALL return RAM to the CPU path in the same cycle.

Configuration
REQ-018 Macro TAITOSJ_HS_WINDOW_EN defined: a hiscore address in [BASE_ADDR, BASE_ADDR+2^ADDR_BITS) is in window; any other address SHALL suppress ram_we and load hs_data_out with 8'hFF.
REQ-019 Macro TAITOSJ_HS_WINDOW_EN undefined: every address SHALL be in window, and REQ-010 translation applies unchecked.

Verification
REQ-020 Handover: pause_cpu=1, hs_access_read=1 at cycle 0 -> hs_granted=1 at cycle SETTLE+2 (=4); RAM path equals CPU path before that.
REQ-021 Read: HS_OWN, hs_address=16'h8123, RAM[0x123]=8'h5A -> hs_data_out=8'h5A 2 cycles later.
REQ-022 Write: HS_OWN, hs_address=16'h87FF, hs_data_in=8'hC3, hs_write=1 for 1 cycle -> exactly one ram_we pulse, ram_addr=11'h7FF; cpu_we=1 concurrently is ignored.
REQ-023 Abort: pause_cpu falls with hs_write=1 -> ram_we=0 that cycle, state CPU_OWN, hs_granted=0 next cycle.
REQ-024 Window (macro on): hs_address=16'h7FFF read -> hs_data_out=8'hFF and no ram_we on write; (macro off) -> RAM[0x7FF] accessed.
REQ-025 Reset: RESET_n low during HS_OWN -> hs_granted=0, hs_data_out=8'h00, CPU path restored without a clock edge.

Source files
------------

// File: rtl/taitosj_hs_bridge.sv
// Hands the work RAM between the CPU and the hiscore engine while the CPU is paused.
// Optional TAITOSJ_HS_WINDOW_EN bounds-checks hiscore addresses against the RAM window.
module taitosj_hs_bridge #(
  parameter logic [15:0] BASE_ADDR = 16'h8000,
  parameter int          ADDR_BITS = 11,
  parameter int          SETTLE    = 2
) (
  input  logic                 clkm_32MHZ,
  input  logic                 RESET_n,
  input  logic                 pause_cpu,
  input  logic                 hs_access_read,
  input  logic                 hs_access_write,
  input  logic [15:0]          hs_address,
  input  logic [7:0]           hs_data_in,
  input  logic                 hs_write,
  output logic [7:0]           hs_data_out,
  output logic                 hs_granted,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [7:0]           cpu_wdata,
  input  logic                 cpu_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [7:0]           ram_wdata,
  output logic                 ram_we,
  input  logic [7:0]           ram_q
);

  typedef enum logic [1:0] {CPU_OWN, SETTLE_IN, HS_OWN} state_t;

  state_t               state;
  logic [3:0]           settle_cnt;
  logic                 oow_q;
  logic                 in_win;
  logic                 intent;
  logic                 hs_own;
  logic [ADDR_BITS-1:0] hs_ram_addr;

  assign intent      = hs_access_read | hs_access_write;
  assign hs_own      = (state == HS_OWN);
  assign hs_ram_addr = hs_address[ADDR_BITS-1:0] - BASE_ADDR[ADDR_BITS-1:0];

`ifdef TAITOSJ_HS_WINDOW_EN
  localparam logic [16:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [16:0] WIN_HI = WIN_LO + 17'(1 << ADDR_BITS);
  assign in_win = ({1'b0, hs_address} >= WIN_LO) && ({1'b0, hs_address} < WIN_HI);
`else
  logic unused_hs_addr_hi;
  assign unused_hs_addr_hi = &{1'b0, hs_address[15:ADDR_BITS]};
  assign in_win = 1'b1;
`endif

  // Mux follows the state register, so async reset returns the CPU path at once.
  // pause_cpu gating keeps a write in the abort cycle away from RAM.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = cpu_we;
    if (hs_own) begin
      ram_addr  = hs_ram_addr;
      ram_wdata = hs_data_in;
      ram_we    = hs_write & in_win & pause_cpu;
    end
  end

  always_ff @(posedge clkm_32MHZ or negedge RESET_n) begin
    if (!RESET_n) begin
      state       <= CPU_OWN;
      settle_cnt  <= 4'd0;
      hs_granted  <= 1'b0;
      hs_data_out <= 8'h00;
      oow_q       <= 1'b0;
    end else begin
      // ram_q lags the address by a cycle; the window flag is delayed to match.
      oow_q <= ~in_win;
      if (hs_own) hs_data_out <= oow_q ? 8'hFF : ram_q;
      case (state)
        CPU_OWN: begin
          hs_granted <= 1'b0;
          if (pause_cpu && intent) begin
            state      <= SETTLE_IN;
            settle_cnt <= 4'(SETTLE);
          end
        end
        SETTLE_IN: begin
          if (!pause_cpu || !intent) begin
            state      <= CPU_OWN;
            settle_cnt <= 4'd0;
          end else if (settle_cnt == 4'd0) begin
            state      <= HS_OWN;
            hs_granted <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        HS_OWN: begin
          if (!pause_cpu || !intent) begin
            state      <= CPU_OWN;
            hs_granted <= 1'b0;
          end
        end
        default: begin
          state      <= CPU_OWN;
          hs_granted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_taitosj_hs_bridge.sv
// Scoreboard bench for taitosj_hs_bridge: timed output expectations plus an expected-write queue.
module tb_taitosj_hs_bridge;

  localparam int AB = 11;

  logic          clk = 1'b0;
  logic          RESET_n;
  logic          pause_cpu, hs_access_read, hs_access_write, hs_write;
  logic [15:0]   hs_address;
  logic [7:0]    hs_data_in, hs_data_out;
  logic          hs_granted;
  logic [AB-1:0] cpu_addr, ram_addr;
  logic [7:0]    cpu_wdata, ram_wdata, ram_q;
  logic          cpu_we, ram_we;

  taitosj_hs_bridge dut (
    .clkm_32MHZ(clk), .RESET_n(RESET_n), .pause_cpu(pause_cpu),
    .hs_access_read(hs_access_read), .hs_access_write(hs_access_write),
    .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_write(hs_write),
    .hs_data_out(hs_data_out), .hs_granted(hs_granted),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Work RAM: synchronous write, registered read (q one cycle after address).
  logic [7:0] mem [0:(1<<AB)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int sel; logic [15:0] exp; } chk_t;
  typedef struct { logic [AB-1:0] addr; logic [7:0] data; } wr_t;
  chk_t chk_q[$];
  wr_t  wr_q[$];
  int   vectors = 0, miscompares = 0;
  bit   mon_en = 1'b0;

  function automatic string sel_name(int s);
    case (s)
      0: return "hs_granted";
      1: return "hs_data_out";
      2: return "ram_addr";
      3: return "ram_we";
      default: return "ram_wdata";
    endcase
  endfunction

  function automatic logic [15:0] sel_val(int s);
    case (s)
      0: return {15'd0, hs_granted};
      1: return {8'd0, hs_data_out};
      2: return {5'd0, ram_addr};
      3: return {15'd0, ram_we};
      default: return {8'd0, ram_wdata};
    endcase
  endfunction

  task automatic push(int c, int s, logic [15:0] e);
    chk_t t;
    t.cyc = c; t.sel = s; t.exp = e;
    chk_q.push_back(t);
  endtask

  task automatic push_wr(logic [AB-1:0] a, logic [7:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  // Monitor: sample mid-cycle, retire timed checks and every observed write.
  always @(negedge clk) begin
    for (int i = chk_q.size() - 1; i >= 0; i--) begin
      if (chk_q[i].cyc <= cyc) begin
        logic [15:0] act;
        act = sel_val(chk_q[i].sel);
        vectors++;
        if (chk_q[i].cyc != cyc || act !== chk_q[i].exp) begin
          miscompares++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", sel_name(chk_q[i].sel), chk_q[i].cyc, act, chk_q[i].exp);
        end
        chk_q.delete(i);
      end
    end
    if (mon_en && ram_we === 1'b1) begin
      vectors++;
      if (wr_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write cyc=%0d got addr=%h data=%h exp none", cyc, ram_addr, ram_wdata);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        if (ram_addr !== w.addr || ram_wdata !== w.data) begin
          miscompares++;
          $display("FAIL write cyc=%0d got addr=%h data=%h exp addr=%h data=%h", cyc, ram_addr, ram_wdata, w.addr, w.data);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(int c);
    while (cyc < c) step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got timeout exp finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, a, w, v, b, s, h, r;
    logic [7:0] exp_v;
    RESET_n = 1'b0; pause_cpu = 1'b0; hs_access_read = 1'b0; hs_access_write = 1'b0;
    hs_write = 1'b0; hs_address = 16'h0000; hs_data_in = 8'h00;
    cpu_addr = '0; cpu_wdata = 8'h00; cpu_we = 1'b0;
    step(1);
    // Preload RAM through the CPU path while the bridge is held in reset.
    cpu_we = 1'b1; cpu_addr = 11'h123; cpu_wdata = 8'h5A; step(1);
    cpu_addr = 11'h7FF; cpu_wdata = 8'h3C; step(1);
    cpu_addr = 11'h010; cpu_wdata = 8'h77; step(1);
    cpu_we = 1'b0; cpu_addr = 11'h055; cpu_wdata = 8'hAA;
    mon_en = 1'b1;
    push(cyc, 0, 16'h0); push(cyc, 1, 16'h00); push(cyc, 2, 16'h055);
    step(1);
    RESET_n = 1'b1;

    // CPU owns RAM: its write passes straight through.
    cpu_we = 1'b1; push_wr(11'h055, 8'hAA); push(cyc, 3, 16'h1);
    step(1);
    cpu_we = 1'b0;

    // Handover: grant lands SETTLE+2 cycles after the request.
    c0 = cyc;
    pause_cpu = 1'b1; hs_access_read = 1'b1; hs_address = 16'h8123;
    push(c0+1, 0, 16'h0); push(c0+1, 3, 16'h0);
    push(c0+2, 0, 16'h0); push(c0+2, 2, 16'h055);
    push(c0+3, 0, 16'h0);
    push(c0+4, 0, 16'h1); push(c0+4, 2, 16'h123);
    push(c0+6, 1, 16'h5A);
    step(1);
    hs_write = 1'b1; hs_data_in = 8'h99;  // dropped while settling
    step(1);
    hs_write = 1'b0;
    wait_to(c0+6);

    // Read latency from an address change.
    a = cyc; hs_address = 16'h8010; push(a+2, 1, 16'h77);
    wait_to(a+2);

    // Single-cycle write at the top of the window; concurrent cpu_we ignored.
    w = cyc;
    hs_address = 16'h87FF; hs_data_in = 8'hC3; hs_write = 1'b1;
    cpu_we = 1'b1; cpu_addr = 11'h055; cpu_wdata = 8'h11;
    push_wr(11'h7FF, 8'hC3); push(w, 2, 16'h7FF); push(w, 4, 16'hC3);
    push(w+1, 3, 16'h0); push(w+3, 1, 16'hC3);
    step(1);
    hs_write = 1'b0; cpu_we = 1'b0;
    wait_to(w+3);

    // Address just below the window.
    v = cyc;
    hs_address = 16'h7FFF; hs_data_in = 8'h5E; hs_write = 1'b1;
`ifdef TAITOSJ_HS_WINDOW_EN
    exp_v = 8'hFF; push(v, 3, 16'h0);
`else
    exp_v = 8'h5E; push_wr(11'h7FF, 8'h5E);
`endif
    push(v+3, 1, {8'h00, exp_v});
    step(1);
    hs_write = 1'b0;
    wait_to(v+4);

    // Abort with a write pending: no RAM write, grant drops, output holds.
    b = cyc;
    hs_address = 16'h8200; hs_data_in = 8'h44; hs_write = 1'b1; pause_cpu = 1'b0;
    push(b, 3, 16'h0); push(b+1, 0, 16'h0); push(b+1, 2, 16'h055);
    push(b+3, 1, {8'h00, exp_v});
    step(1);
    hs_write = 1'b0; hs_access_read = 1'b0;
    wait_to(b+4);

    // Intent drops mid-settle: never granted.
    s = cyc;
    pause_cpu = 1'b1; hs_access_write = 1'b1;
    for (int k = 1; k <= 5; k++) push(s+k, 0, 16'h0);
    step(2);
    hs_access_write = 1'b0;
    wait_to(s+6);

    // Full handover, then release by dropping intent.
    h = cyc;
    hs_access_read = 1'b1; hs_address = 16'h8123;
    push(h+4, 0, 16'h1); push(h+6, 1, 16'h5A);
    wait_to(h+6);
    hs_access_read = 1'b0;
    push(h+7, 0, 16'h0); push(h+7, 2, 16'h055);
    wait_to(h+8);

    // Reset in HS_OWN restores the CPU path without a clock edge.
    r = cyc;
    hs_access_read = 1'b1;
    push(r+4, 0, 16'h1);
    wait_to(r+5);
    RESET_n = 1'b0; hs_write = 1'b1; hs_data_in = 8'h66;
    push(r+5, 0, 16'h0); push(r+5, 1, 16'h00); push(r+5, 2, 16'h055); push(r+5, 3, 16'h0);
    step(1);
    hs_write = 1'b0;
    wait_to(r+7);

    vectors++;
    if (chk_q.size() != 0 || wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got chk=%0d wr=%0d exp 0 0", chk_q.size(), wr_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
